// File: rtl/rtc_bus_arbiter.sv
// Round-robin arbiter for the shared RTC register bus: grants one single-register
// read or write at a time and sequences address setup, RD/WR strobe and hold.
module rtc_bus_arbiter #(
   parameter int N             = 3,
   parameter int SETUP_CYCLES  = 2,
   parameter int STROBE_CYCLES = 256,
   parameter int HOLD_CYCLES   = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   we,
   input  logic [8*N-1:0] addr,
   input  logic [8*N-1:0] wdata,
   output logic [N-1:0]   grant,
   output logic [N-1:0]   done,
   output logic [7:0]     rdata,
   output logic           busy,
   output logic [7:0]     dir_out,
   output logic [7:0]     data_out,
   output logic           data_oe,
   input  logic [7:0]     data_in,
   output logic           RD,
   output logic           WR,
   output logic [2:0]     state_dbg
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam logic [8:0] SETUP_LAST  = 9'(SETUP_CYCLES - 1);
   localparam logic [8:0] STROBE_LAST = 9'(STROBE_CYCLES - 1);
   localparam logic [8:0] HOLD_LAST   = 9'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_STROBE = 3'd2,
      S_HOLD   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [8:0]      cnt_q, cnt_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   win_q, win_d;
   logic            we_q, we_d;
   logic [N-1:0]    grant_q, grant_d;
   logic [7:0]      dir_q, dir_d;
   logic [7:0]      dout_q, dout_d;
   logic            oe_q, oe_d;
   logic [7:0]      rdata_q, rdata_d;

   logic [2*N-1:0]  req_dbl;
   logic [N-1:0]    req_rot;
   logic [PW:0]     win_sum;
   logic [PW-1:0]   win_sel;
   logic            found;
   logic            sel_we;
   logic [7:0]      sel_addr;
   logic [7:0]      sel_wdata;
   logic [N-1:0]    sel_onehot;

   // Rotate requests so bit 0 is the requester at the round-robin pointer.
   always_comb begin
      req_dbl = {req, req};
      req_rot = N'(req_dbl >> ptr_q);
      found   = 1'b0;
      win_sum = '0;
      for (int k = 0; k < N; k++) begin
         if (!found && req_rot[k]) begin
            found   = 1'b1;
            win_sum = {1'b0, ptr_q} + (PW+1)'(k);
         end
      end
      if (win_sum >= (PW+1)'(N)) win_sum = win_sum - (PW+1)'(N);
      win_sel = win_sum[PW-1:0];
   end

   always_comb begin
      sel_we     = 1'b0;
      sel_addr   = '0;
      sel_wdata  = '0;
      sel_onehot = '0;
      for (int k = 0; k < N; k++) begin
         if (win_sel == PW'(k)) begin
            sel_we        = we[k];
            sel_addr      = addr[8*k +: 8];
            sel_wdata     = wdata[8*k +: 8];
            sel_onehot[k] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      ptr_d   = ptr_q;
      win_d   = win_q;
      we_d    = we_q;
      grant_d = grant_q;
      dir_d   = dir_q;
      dout_d  = dout_q;
      oe_d    = oe_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            grant_d = '0;
            if (found) begin
               state_d = S_SETUP;
               win_d   = win_sel;
               we_d    = sel_we;
               grant_d = sel_onehot;
               dir_d   = sel_addr;
               oe_d    = sel_we;
               if (sel_we) dout_d = sel_wdata;
            end
         end
         S_SETUP: begin
            if (cnt_q == SETUP_LAST) state_d = S_STROBE;
            else                     cnt_d   = cnt_q + 9'd1;
         end
         S_STROBE: begin
            if (cnt_q == STROBE_LAST) begin
               state_d = S_HOLD;
               if (!we_q) rdata_d = data_in;
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         S_HOLD: begin
            if (cnt_q == HOLD_LAST) state_d = S_DONE;
            else                    cnt_d   = cnt_q + 9'd1;
         end
         S_DONE: begin
            state_d = S_IDLE;
            grant_d = '0;
            oe_d    = 1'b0;
            ptr_d   = (win_q == PW'(N-1)) ? '0 : win_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         win_q   <= '0;
         we_q    <= 1'b0;
         grant_q <= '0;
         dir_q   <= '0;
         dout_q  <= '0;
         oe_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         we_q    <= we_d;
         grant_q <= grant_d;
         dir_q   <= dir_d;
         dout_q  <= dout_d;
         oe_q    <= oe_d;
         rdata_q <= rdata_d;
      end
   end

   // Strobes decode straight from the state flop so a reset drops them on the same edge.
   always_comb begin
      done = '0;
      for (int k = 0; k < N; k++) begin
         done[k] = (state_q == S_DONE) && (win_q == PW'(k));
      end
   end

   assign grant     = grant_q;
   assign busy      = (state_q != S_IDLE);
   assign RD        = (state_q == S_STROBE) && !we_q;
   assign WR        = (state_q == S_STROBE) && we_q;
   assign dir_out   = dir_q;
   assign data_out  = dout_q;
   assign data_oe   = oe_q;
   assign rdata     = rdata_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Scoreboard bench for rtc_bus_arbiter (SETUP=1, STROBE=4, HOLD=1, N=3): the driver queues
// expected transactions, a negedge monitor checks grants, strobe widths, latency and done data.
module tb_rtc_bus_arbiter;

   localparam int EW = 28;  // {owner[2:0], we, addr[7:0], wdata[7:0], rdata[7:0]}

   logic        clk;
   logic        reset;
   logic [2:0]  req;
   logic [2:0]  we_r;
   logic [7:0]  a_r [3];
   logic [7:0]  d_r [3];
   logic [23:0] addr;
   logic [23:0] wdata;
   logic [2:0]  grant;
   logic [2:0]  done;
   logic [7:0]  rdata;
   logic        busy;
   logic [7:0]  dir_out;
   logic [7:0]  data_out;
   logic        data_oe;
   logic [7:0]  data_in;
   logic        rd_s;
   logic        wr_s;
   logic [2:0]  state_dbg;

   assign addr  = {a_r[2], a_r[1], a_r[0]};
   assign wdata = {d_r[2], d_r[1], d_r[0]};

   rtc_bus_arbiter #(
      .N(3), .SETUP_CYCLES(1), .STROBE_CYCLES(4), .HOLD_CYCLES(1)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .we(we_r), .addr(addr), .wdata(wdata),
      .grant(grant), .done(done), .rdata(rdata), .busy(busy), .dir_out(dir_out),
      .data_out(data_out), .data_oe(data_oe), .data_in(data_in), .RD(rd_s), .WR(wr_s),
      .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   int total = 0;
   int bad = 0;
   int overlap = 0;
   bit b2b = 1'b0;
   bit last_done_valid = 1'b0;
   int last_done_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic expect_txn(input logic [1:0] i, input logic w, input logic [7:0] a,
                             input logic [7:0] d, input logic [7:0] rx);
      logic [2:0] own;
      own = 3'b001 << i;
      exp_q.push_back({own, w, a, d, rx});
   endtask

   task automatic post(input logic [1:0] i, input logic w, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] rx);
      we_r[i] = w;
      a_r[i]  = a;
      d_r[i]  = d;
      req[i]  = 1'b1;
      expect_txn(i, w, a, d, rx);
   endtask

   task automatic wait_done(input logic [2:0] mask);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if ((done & mask) != 3'b000) begin
            ok = 1'b1;
            break;
         end
      end
      check("done_wait", 32'(ok), 32'd1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      req = 3'b000;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // ---------------- monitor ----------------
   logic [2:0] prev_grant = 3'b000;
   logic [2:0] prev_done = 3'b000;
   int rd_len = 0;
   int wr_len = 0;
   bit saw_rd = 1'b0;
   bit saw_wr = 1'b0;
   int grant_cyc = 0;

   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (reset) begin
         rd_len = 0;
         wr_len = 0;
      end else begin
         if (rd_s && wr_s) overlap++;
         if (rd_s) rd_len++;
         else if (rd_len != 0) begin
            check("rd_width", 32'(rd_len), 32'd4);
            rd_len = 0;
         end
         if (wr_s) wr_len++;
         else if (wr_len != 0) begin
            check("wr_width", 32'(wr_len), 32'd4);
            wr_len = 0;
         end
         if (rd_s) saw_rd = 1'b1;
         if (wr_s) saw_wr = 1'b1;
         if (prev_done != 3'b000) begin
            check("done_pulse_width", 32'(done), 32'd0);
            check("idle_after_done", 32'({busy, grant}), 32'd0);
         end
         if (grant != 3'b000 && prev_grant == 3'b000) begin
            saw_rd = 1'b0;
            saw_wr = 1'b0;
            grant_cyc = cyc;
            if (exp_q.size() == 0) check("grant_unexpected", 32'(grant), 32'd0);
            else begin
               e = exp_q[0];
               check("grant_owner", 32'(grant), 32'(e[27:25]));
               check("grant_dir_out", 32'(dir_out), 32'(e[23:16]));
               check("grant_data_oe", 32'(data_oe), 32'(e[24]));
               if (e[24]) check("grant_data_out", 32'(data_out), 32'(e[15:8]));
            end
            if (b2b && last_done_valid) check("idle_gap", 32'(cyc - last_done_cyc), 32'd2);
         end
         if (done != 3'b000) begin
            if (exp_q.size() == 0) check("done_unexpected", 32'(done), 32'd0);
            else begin
               e = exp_q.pop_front();
               check("done_owner", 32'(done), 32'(e[27:25]));
               check("done_grant_held", 32'(grant), 32'(e[27:25]));
               check("done_latency", 32'(cyc - grant_cyc), 32'd6);
               check("done_saw_rd", 32'(saw_rd), 32'(!e[24]));
               check("done_saw_wr", 32'(saw_wr), 32'(e[24]));
               check("done_dir_out", 32'(dir_out), 32'(e[23:16]));
               if (e[24]) check("done_data_out", 32'(data_out), 32'(e[15:8]));
               else       check("done_rdata", 32'(rdata), 32'(e[7:0]));
            end
            last_done_cyc = cyc;
            last_done_valid = 1'b1;
         end
      end
      prev_grant = grant;
      prev_done = done;
   end

   // ---------------- directed stimulus ----------------
   initial begin
      bit ok;
      reset = 1'b1;
      req = 3'b000;
      we_r = 3'b000;
      for (int k = 0; k < 3; k++) begin
         a_r[k] = 8'h00;
         d_r[k] = 8'h00;
      end
      data_in = 8'h00;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_strobes", 32'({rd_s, wr_s}), 32'd0);
      check("rst_data_oe", 32'(data_oe), 32'd0);
      check("rst_buses", 32'({dir_out, data_out, rdata}), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);

      // single write from requester 0
      post(2'd0, 1'b1, 8'h21, 8'h45, 8'h00);
      wait_done(3'b001);
      req[0] = 1'b0;

      // single read from requester 1; rdata must hold afterwards
      data_in = 8'h37;
      post(2'd1, 1'b0, 8'h10, 8'h00, 8'h37);
      wait_done(3'b010);
      req[1] = 1'b0;
      data_in = 8'hEE;
      repeat (3) @(negedge clk);
      check("rdata_hold", 32'(rdata), 32'h37);
      check("idle_oe_low", 32'(data_oe), 32'd0);

      // all three held after reset: 0,1,2,0 with one idle cycle between
      do_reset();
      @(negedge clk);
      b2b = 1'b1;
      last_done_valid = 1'b0;
      data_in = 8'hC3;
      post(2'd0, 1'b1, 8'h30, 8'h5A, 8'h00);
      post(2'd1, 1'b0, 8'h31, 8'h00, 8'hC3);
      post(2'd2, 1'b1, 8'h32, 8'hA5, 8'h00);
      expect_txn(2'd0, 1'b1, 8'h30, 8'h5A, 8'h00);
      wait_done(3'b001);
      wait_done(3'b010);
      wait_done(3'b100);
      wait_done(3'b001);
      req = 3'b000;
      b2b = 1'b0;

      // requester 2 drops req right after grant; transaction still completes
      @(negedge clk);
      post(2'd2, 1'b1, 8'h44, 8'h99, 8'h00);
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (grant[2]) begin
            ok = 1'b1;
            break;
         end
      end
      check("t4_grant_wait", 32'(ok), 32'd1);
      @(posedge clk);
      #1 req[2] = 1'b0;
      wait_done(3'b100);

      // reset in the middle of a read strobe aborts it
      @(negedge clk);
      data_in = 8'h6B;
      post(2'd0, 1'b0, 8'h55, 8'h00, 8'h6B);
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (rd_s) begin
            ok = 1'b1;
            break;
         end
      end
      check("t5_rd_wait", 32'(ok), 32'd1);
      @(posedge clk);
      #1 reset = 1'b1;
      req = 3'b000;
      @(posedge clk);
      @(negedge clk);
      check("abort_strobes", 32'({rd_s, wr_s}), 32'd0);
      check("abort_grant", 32'(grant), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (10) @(negedge clk);
      data_in = 8'h8E;
      post(2'd0, 1'b1, 8'h66, 8'h77, 8'h00);
      post(2'd1, 1'b0, 8'h67, 8'h00, 8'h8E);
      wait_done(3'b001);
      req[0] = 1'b0;
      wait_done(3'b010);
      req[1] = 1'b0;

      // lone requester 1 is granted straight from IDLE every time
      data_in = 8'h5C;
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         post(2'd1, r[0], 8'h12 + 8'(r), 8'hB0 + 8'(r), 8'h5C);
         @(negedge clk);
         check("t6_immediate_grant", 32'(grant), 32'b010);
         wait_done(3'b010);
         req[1] = 1'b0;
      end

      repeat (4) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      check("strobe_overlap", 32'(overlap), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rtc_bus_arbiter.md
Name: rtc_bus_arbiter

Overview:
Shares the single RTC register bus (address, data, RD, WR strobes) among N requesters: the chrono-reset sequencer, the time/date set logic and the periodic clock-read refresh. Each requester posts one single-register transaction (read or write) and receives a grant, a completion pulse and read data. The block applies round-robin arbitration and generates the address-setup, strobe and hold timing the RTC needs. It sits between the requester FSMs and the top-level RTC pin drivers.

Parameters:
N, 3, number of requesters (index 0..N-1)
SETUP_CYCLES, 2, cycles address/data are stable before the strobe (min 1)
STROBE_CYCLES, 256, cycles RD or WR is held high (min 1, max 511)
HOLD_CYCLES, 2, cycles address/data stay stable after the strobe (min 1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  N  per-requester transaction request, level
we  in  N  per-requester op: 1 = write, 0 = read
addr  in  8*N  per-requester register address, requester i at bits [8i+7:8i]
wdata  in  8*N  per-requester write data, same packing
grant  out  N  one-hot; owner of the current transaction
done  out  N  one-cycle pulse to the owner at transaction end
rdata  out  8  data captured on the last read; valid while done is high, held until next read
busy  out  1  high in every non-IDLE state
dir_out  out  8  RTC register address
data_out  out  8  RTC write data
data_oe  out  1  drive enable for data_out (writes only)
data_in  in  8  RTC data bus read value
RD  out  1  read strobe, active high
WR  out  1  write strobe, active high

Behaviour:
- Reset (synchronous, active-high): state IDLE, round-robin pointer 0; grant, done, busy, RD, WR, data_oe = 0; dir_out, data_out, rdata = 0. Reset mid-transaction aborts it: strobes drop on that edge, no done is issued.
- States: IDLE -> SETUP -> STROBE -> HOLD -> DONE -> IDLE. One 9-bit phase counter, cleared on every state entry.
- IDLE: if any req is high at a clock edge, winner = first requester with req high, searching pointer, pointer+1, ... mod N. On that edge: latch the winner's we, addr and wdata; set grant[winner]; drive dir_out (and data_out with data_oe=1 if write); go to SETUP. No req: stay IDLE; outputs hold, grant = 0.
- SETUP: lasts exactly SETUP_CYCLES, then STROBE.
- STROBE: RD (read) or WR (write) high for exactly STROBE_CYCLES. RD and WR are never high together. For a read, rdata <= data_in on the edge that leaves STROBE.
- HOLD: lasts HOLD_CYCLES with strobes low and dir_out/data_out unchanged, then DONE.
- DONE: one cycle; done[winner]=1, grant still held. On exit: grant=0, data_oe=0, pointer = (winner+1) mod N, go to IDLE.
- Arbitration starts only from IDLE, so there is one idle cycle between back-to-back transactions.
- Latency from the req-sampling edge to done high = SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES cycles; done lasts 1 cycle.
- req, we, addr and wdata are sampled only at grant. Later changes (including req dropping) do not affect the transaction, and done is still issued. A requester wanting one transaction deasserts req in the cycle done is high; if req is still high it competes again at lower priority.
- dir_out/data_out keep their last values in IDLE; data_oe=0 in IDLE.
- Simultaneous requests: exactly one grant; the others wait without loss.

Test Plan:
(Params SETUP=1, STROBE=4, HOLD=1, N=3.)
1. Reset, then req=3'b001, we[0]=1, addr0=8'h21, wdata0=8'h45 -> grant=001 next cycle; dir_out=21, data_out=45, data_oe=1; WR high exactly 4 cycles; RD=0 throughout; done[0] pulse 6 cycles after the sampling edge.
2. req[1] read addr 8'h10 with data_in=8'h37 during the strobe -> RD high 4 cycles, rdata=37 when done[1]=1; rdata holds after req drops.
3. req=3'b111 held continuously after reset -> grants in order 001, 010, 100, 001; one IDLE cycle between transactions.
4. req[2] drops one cycle after grant -> transaction completes with full strobe timing; done[2] still pulses.
5. reset asserted during STROBE -> next edge RD/WR=0, grant=0, busy=0, no done; pointer=0 (a later req=3'b011 is granted to 0).
6. Only req[1] asserted repeatedly (deasserted on done) -> each time granted immediately from IDLE regardless of pointer; pointer advances to 2.
